// File: rtl/fabric_local_port.sv
// Local port between a tile core and its mesh router: injection FIFO with XY routing, ejection FIFO to the core.
// Optional FABRIC_LOCAL_LOOPBACK_EN: self-addressed flits go straight to the ejection FIFO instead of being dropped.

module fabric_local_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];

    // extra wrap bit distinguishes full from empty when the index bits match
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module fabric_local_port #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int MAX_OUTST = 8,
    localparam int TRANS_W  = 18 + ADDR_W + DATA_W,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         local_tile_id,
    input  logic               core_req_valid,
    output logic               core_req_ready,
    input  logic [1:0]         core_req_opcode,
    input  logic [7:0]         core_req_dest,
    input  logic [ADDR_W-1:0]  core_req_addr,
    input  logic [DATA_W-1:0]  core_req_data,
    output logic               out_local_req_valid,
    output logic [TRANS_W-1:0] out_local_req,
    input  logic [3:0]         in_local_ready,
    input  logic               in_local_req_valid,
    input  logic [TRANS_W-1:0] in_local_req,
    output logic               out_local_ready,
    output logic               core_rsp_valid,
    input  logic               core_rsp_ready,
    output logic [TRANS_W-1:0] core_rsp,
    output logic [CNT_W-1:0]   outst_cnt,
    output logic               err_loopback
);
    localparam logic [1:0] OP_RD     = 2'b00;
    localparam logic [1:0] OP_WR     = 2'b01;
    localparam logic [1:0] OP_RD_RSP = 2'b10;

    typedef struct packed {
        logic [1:0]        opcode;
        logic [7:0]        dest;
        logic [7:0]        src;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } flit_t;

    flit_t inj_wdata, inj_head, ej_wdata, ej_head;
    logic  inj_push, inj_pop, inj_full, inj_empty;
    logic  ej_push, ej_pop, ej_full, ej_empty;
    logic  head_loop, fwd_pop, loop_pop, router_wr;
    logic  [1:0] dir;
    logic  cnt_inc, cnt_dec;

    assign core_req_ready = !inj_full &&
                            !(core_req_opcode == OP_RD && outst_cnt == CNT_W'(MAX_OUTST));
    assign inj_push  = core_req_valid && core_req_ready;
    assign inj_wdata = '{opcode: core_req_opcode, dest: core_req_dest, src: local_tile_id,
                         addr: core_req_addr, data: core_req_data};

    fabric_local_fifo #(.W(TRANS_W), .DEPTH(INJ_DEPTH)) u_inj (
        .clk(clk), .rst(rst), .push(inj_push), .pop(inj_pop), .wdata(inj_wdata),
        .rdata(inj_head), .full(inj_full), .empty(inj_empty)
    );

    // XY dimension-order routing of the injection head
    always_comb begin
        dir       = 2'd0;
        head_loop = 1'b0;
        if (inj_head.dest[7:4] > local_tile_id[7:4])      dir = 2'd1;
        else if (inj_head.dest[7:4] < local_tile_id[7:4]) dir = 2'd2;
        else if (inj_head.dest[3:0] > local_tile_id[3:0]) dir = 2'd3;
        else if (inj_head.dest[3:0] < local_tile_id[3:0]) dir = 2'd0;
        else                                              head_loop = 1'b1;
    end

    assign out_local_req_valid = !inj_empty && !head_loop;
    assign out_local_req       = inj_head;
    assign fwd_pop             = out_local_req_valid && in_local_ready[dir];
    assign out_local_ready     = !ej_full;
    assign router_wr           = in_local_req_valid && out_local_ready;
    assign inj_pop             = fwd_pop || loop_pop;

`ifdef FABRIC_LOCAL_LOOPBACK_EN
    // router flits win the ejection write port; a loopback head waits for a free cycle
    assign loop_pop     = !inj_empty && head_loop && !ej_full && !router_wr;
    assign ej_push      = router_wr || loop_pop;
    assign ej_wdata     = router_wr ? flit_t'(in_local_req) : inj_head;
    assign err_loopback = 1'b0;
`else
    logic err_q;
    assign loop_pop     = !inj_empty && head_loop;
    assign ej_push      = router_wr;
    assign ej_wdata     = flit_t'(in_local_req);
    assign err_loopback = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          err_q <= 1'b0;
        else if (loop_pop) err_q <= 1'b1;
    end
`endif

    fabric_local_fifo #(.W(TRANS_W), .DEPTH(EJ_DEPTH)) u_ej (
        .clk(clk), .rst(rst), .push(ej_push), .pop(ej_pop), .wdata(ej_wdata),
        .rdata(ej_head), .full(ej_full), .empty(ej_empty)
    );

    assign core_rsp_valid = !ej_empty;
    assign core_rsp       = ej_head;
    assign ej_pop         = core_rsp_valid && core_rsp_ready;

    // reads count as outstanding from the moment they leave the injection FIFO
    assign cnt_inc = inj_pop && (inj_head.opcode == OP_RD);
    assign cnt_dec = ej_pop && (ej_head.opcode == OP_RD_RSP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst_cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10: if (outst_cnt != CNT_W'(MAX_OUTST)) outst_cnt <= outst_cnt + 1'b1;
                2'b01: if (outst_cnt != '0)                outst_cnt <= outst_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    logic unused_op;
    assign unused_op = ^OP_WR;
endmodule

// File: doc/fabric_local_port.md
FABRIC_LOCAL_PORT -- requirements
Module: fabric_local_port

Interface
REQ-001 Parameters (name, default, meaning); TRANS_W = 18+ADDR_W+DATA_W:
- DATA_W, 32, payload width.
- ADDR_W, 32, address width.
- INJ_DEPTH, 4, injection FIFO entries; power of 2, minimum 2.
- EJ_DEPTH, 4, ejection FIFO entries; power of 2, minimum 2.
- MAX_OUTST, 8, outstanding-read limit; minimum 1.
REQ-002 clk  in  1  single clock; all state is rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 local_tile_id  in  8  this tile; [7:4]=x, [3:0]=y.
REQ-005 core_req_valid  in  1 / core_req_ready  out  1  core request handshake.
REQ-006 core_req_opcode  in  2  00=RD, 01=WR, 10=RD_RSP.
REQ-007 core_req_dest  in  8 / core_req_addr  in  ADDR_W / core_req_data  in  DATA_W  request fields.
REQ-008 out_local_req_valid  out  1 / out_local_req  out  TRANS_W  flit to router; packed MSB-first as {opcode, dest, src, addr, data}.
REQ-009 in_local_ready  in  4  router arbiter readies; [0]=north, [1]=east, [2]=west, [3]=south.
REQ-010 in_local_req_valid  in  1 / in_local_req  in  TRANS_W / out_local_ready  out  1  flit from router.
REQ-011 core_rsp_valid  out  1 / core_rsp_ready  in  1 / core_rsp  out  TRANS_W  delivery to core.
REQ-012 outst_cnt  out  $clog2(MAX_OUTST+1)  reads in flight.
REQ-013 err_loopback  out  1  sticky error flag.

Function
REQ-014 core_req_ready = inj FIFO not full AND NOT (opcode==RD AND outst_cnt==MAX_OUTST).
REQ-015 On an accepted core request, the flit is written into the inj FIFO with src=local_tile_id; out_local_req_valid rises the next cycle (1-cycle latency).
REQ-016 Head route, XY order:
- dest.x>local.x -> east (1); dest.x<local.x -> west (2).
- dest.x equal: dest.y>local.y -> south (3); dest.y<local.y -> north (0).
- dest==local_tile_id -> loopback.
REQ-017 A non-loopback head pops when out_local_req_valid AND in_local_ready[dir]; out_local_req_valid is asserted only for non-loopback heads.
REQ-018 out_local_ready = ej FIFO not full; a router flit is written when in_local_req_valid AND out_local_ready.
REQ-019 core_rsp_valid = ej FIFO not empty; core_rsp is the ej FIFO head; it pops on core_rsp_valid AND core_rsp_ready.
REQ-020 Ej FIFO: a pushed flit is visible on core_rsp_valid the next cycle; a simultaneous push and pop when full is not allowed (out_local_ready is already 0).
REQ-021 outst_cnt:
- +1 when an RD pops from the inj FIFO (loopback pop included).
- -1 when a flit with opcode RD_RSP pops from the ej FIFO.
- Increment and decrement in the same cycle leave it unchanged.
- It saturates at 0 and never exceeds MAX_OUTST.
REQ-022 Both FIFO pointers wrap modulo depth; full and empty are exact (an extra pointer bit or an occupancy counter).
REQ-023 A simultaneous inj push and pop at full is not allowed (ready=0); at empty, a push is never bypassed to the output.

Reset
REQ-024 While rst=0: both FIFOs empty, outst_cnt=0, err_loopback=0, out_local_req_valid=0, core_rsp_valid=0, core_req_ready=1, out_local_ready=1.
REQ-025 A reset asserted mid-transfer discards all buffered flits; no partial state survives.

Configuration
REQ-026 Macro FABRIC_LOCAL_LOOPBACK_EN.
- Defined: a loopback head is written into the ej FIFO when the ej FIFO is not full AND no router flit is being written that cycle (router has priority); otherwise the head stalls.
- Not defined: a loopback head is popped and dropped, and err_loopback sets and stays set until reset.

Verification
REQ-027 local=0x11: WR dest=0x31 -> out_local_req_valid the next cycle; it pops only when in_local_ready=4'b0010; src field=0x11.
REQ-028 MAX_OUTST=2: three RDs to 0x12 -> the third sees core_req_ready=0; after one RD_RSP pops at the core, the third is accepted and outst_cnt=2.
REQ-029 in_local_ready=0, INJ_DEPTH=4: 4 writes -> core_req_ready=0; set in_local_ready[3]=1 for dest 0x15 -> 4 flits drain in order, one per cycle.
REQ-030 With FABRIC_LOCAL_LOOPBACK_EN: WR dest=0x11 plus a router flit in the same cycle -> the router flit is delivered first, then the loopback flit; err_loopback=0. Without the macro: the WR is dropped and err_loopback=1.
REQ-031 core_rsp_ready=0 with EJ_DEPTH=4: after 4 router flits, out_local_ready=0; rst pulled low mid-stream -> all outputs take their REQ-024 values asynchronously.
